// File: rtl/jtag_bsr_seg_pkg.sv
// jtag_pkg: constants and helpers shared by the segmented boundary-scan
// register and the instruction decoder.
//   BSR_SEG_LEN_DEF / BSR_N_SEG_DEF : default geometry
//   bsr_len_w()                     : width of the chain_len output
//   bsr_chain_len()                 : cell-chain length for a segment-enable mask
package jtag_pkg;

  localparam int BSR_SEG_LEN_DEF = 8;
  localparam int BSR_N_SEG_DEF   = 4;
  // Widest segment-enable mask bsr_chain_len() accepts.
  localparam int BSR_MAX_SEG     = 64;

  function automatic int bsr_len_w(input int n_seg, input int seg_len);
    return $clog2(n_seg * seg_len + 1);
  endfunction

  // An enabled segment contributes its cells; a bypassed one contributes its
  // single bypass flop.
  function automatic int bsr_chain_len(input logic [BSR_MAX_SEG-1:0] seg_en,
                                       input int seg_len, input int n_seg);
    int acc;
    acc = 0;
    for (int s = 0; s < n_seg; s++)
      acc += seg_en[s] ? seg_len : 1;
    return acc;
  endfunction

endpackage

// File: rtl/jtag_bsr_seg_if.sv
// jtag_bsr_seg_if: TAP-side bundle for the segmented boundary-scan register.
//   master : TAP controller / test logic (drives enables, TDI, pin data)
//   slave  : jtag_bsr_seg (drives TDO, data_out, seg_en, chain_len)
interface jtag_bsr_seg_if
  import jtag_pkg::*;
#(
  parameter int SEG_LEN = BSR_SEG_LEN_DEF,
  parameter int N_SEG   = BSR_N_SEG_DEF
);
  localparam int W   = N_SEG * SEG_LEN;
  localparam int CLW = bsr_len_w(N_SEG, SEG_LEN);

  logic           capture_en;
  logic           shift_en;
  logic           update_en;
  logic           sel_cfg;
  logic           mode;
  logic           scan_in;
  logic [W-1:0]   data_in;
  logic           scan_out;
  logic [W-1:0]   data_out;
  logic [N_SEG-1:0] seg_en;
  logic [CLW-1:0] chain_len;

  modport master (
    output capture_en, shift_en, update_en, sel_cfg, mode, scan_in, data_in,
    input  scan_out, data_out, seg_en, chain_len
  );

  modport slave (
    input  capture_en, shift_en, update_en, sel_cfg, mode, scan_in, data_in,
    output scan_out, data_out, seg_en, chain_len
  );
endinterface

// File: rtl/jtag_bsr_seg_segment.sv
// jtag_bsr_segment: one boundary-scan segment.
//   SEG_LEN scan cells, SEG_LEN update regs and one bypass flop.
//   en=1 : cells form the segment's chain, scan_out = cells[0]
//   en=0 : cells/update regs hold, bypass flop is the chain
//   data_out : update register contents (the top applies the mode mux)
// Enables arrive already qualified by the top (inactive while sel_cfg=1).
module jtag_bsr_segment #(
  parameter int                 SEG_LEN = 8,
  parameter logic [SEG_LEN-1:0] SAFE    = '0
) (
  input  logic               clockDR,
  input  logic               reset_bar,
  input  logic               en,
  input  logic               capture_en,
  input  logic               shift_en,
  input  logic               update_en,
  input  logic               scan_in,
  output logic               scan_out,
  input  logic [SEG_LEN-1:0] data_in,
  output logic [SEG_LEN-1:0] data_out
);
  logic [SEG_LEN-1:0] cells, upd;
  logic               byp;
  logic [SEG_LEN:0]   shifted;

  // Right shift with scan_in entering the MSB; also valid for SEG_LEN=1.
  assign shifted = {scan_in, cells} >> 1;

  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar) begin
      cells <= '0;
      upd   <= SAFE;
      byp   <= 1'b0;
    end else if (en) begin
      // Update sees the pre-edge cells even when capture/shift fire too.
      if (update_en)       upd   <= cells;
      if (capture_en)      cells <= data_in;
      else if (shift_en)   cells <= shifted[SEG_LEN-1:0];
    end else begin
      if (capture_en)      byp   <= 1'b0;
      else if (shift_en)   byp   <= scan_in;
    end
  end

  assign scan_out = en ? cells[0] : byp;
  assign data_out = upd;
endmodule

// File: rtl/jtag_bsr_seg.sv
// jtag_bsr_seg: segmented boundary-scan register.
//   clockDR   : free-running scan clock, rising edge
//   reset_bar : asynchronous active-low reset
//   bus       : jtag_bsr_seg_if.slave (enables, TDI/TDO, pin data, status)
// sel_cfg=1 routes TDI/TDO through the N_SEG-bit config register that loads
// seg_en; sel_cfg=0 routes through the segments, highest segment nearest TDI.
module jtag_bsr_seg
  import jtag_pkg::*;
#(
  parameter int                         SEG_LEN    = BSR_SEG_LEN_DEF,
  parameter int                         N_SEG      = BSR_N_SEG_DEF,
  parameter logic [N_SEG*SEG_LEN-1:0]   SAFE_VALUE = '0
) (
  input  logic           clockDR,
  input  logic           reset_bar,
  jtag_bsr_seg_if.slave  bus
);
  localparam int W   = N_SEG * SEG_LEN;
  localparam int CLW = bsr_len_w(N_SEG, SEG_LEN);

  logic [N_SEG-1:0] cfg_scan, seg_en;
  logic [N_SEG:0]   cfg_shifted;
  logic [N_SEG:0]   link;       // link[s+1] feeds segment s, link[0] is chain out
  logic [W-1:0]     upd;
  logic             cell_cap, cell_sh, cell_up;

  assign cfg_shifted = {bus.scan_in, cfg_scan} >> 1;

  always_ff @(posedge clockDR or negedge reset_bar) begin
    if (!reset_bar) begin
      cfg_scan <= '0;
      seg_en   <= '1;
    end else if (bus.sel_cfg) begin
      if (bus.update_en)      seg_en   <= cfg_scan;
      if (bus.capture_en)     cfg_scan <= seg_en;
      else if (bus.shift_en)  cfg_scan <= cfg_shifted[N_SEG-1:0];
    end
  end

  // Segments only see enables while the cell chain is selected.
  assign cell_cap = bus.capture_en & ~bus.sel_cfg;
  assign cell_sh  = bus.shift_en   & ~bus.sel_cfg;
  assign cell_up  = bus.update_en  & ~bus.sel_cfg;

  assign link[N_SEG] = bus.scan_in;

  for (genvar s = 0; s < N_SEG; s++) begin : g_seg
    jtag_bsr_segment #(
      .SEG_LEN (SEG_LEN),
      .SAFE    (SAFE_VALUE[s*SEG_LEN +: SEG_LEN])
    ) u_seg (
      .clockDR    (clockDR),
      .reset_bar  (reset_bar),
      .en         (seg_en[s]),
      .capture_en (cell_cap),
      .shift_en   (cell_sh),
      .update_en  (cell_up),
      .scan_in    (link[s+1]),
      .scan_out   (link[s]),
      .data_in    (bus.data_in[s*SEG_LEN +: SEG_LEN]),
      .data_out   (upd[s*SEG_LEN +: SEG_LEN])
    );
  end

  assign bus.scan_out  = bus.sel_cfg ? cfg_scan[0] : link[0];
  assign bus.data_out  = bus.mode ? upd : bus.data_in;
  assign bus.seg_en    = seg_en;
  assign bus.chain_len = CLW'(bsr_chain_len(BSR_MAX_SEG'(seg_en), SEG_LEN, N_SEG));
endmodule
